tile_sched: RTL and testbench

TILE_SCHED -- requirements
Module: tile_sched

---
 rtl/tile_sched.sv | 172 +++++++++++++++++
 tb/tb_tile_sched.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_sched.sv
`default_nettype none
// ============================================================================
// Module      : tile_sched
// Description : Three-stage tile pipeline scheduler. Runs a layer of N tiles
//               as N+2 phases. Each phase launches whichever of the load,
//               compute and writeback engines are active, waits for their
//               done pulses, then pulses state_rst to rotate the A/B/C
//               buffers and moves on to the next phase.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               cfg_valid/ready    - layer start handshake, cfg_tiles = N
//               ld/cp/wb_start     - one-cycle engine start pulses
//               ld/cp/wb_done      - one-cycle engine completion pulses
//               state_rst          - one-cycle buffer-rotation pulse
//               phase              - current phase index (TILE_W+1 bits)
//               busy, layer_done   - activity flag, end-of-layer pulse
// Revision    : 1.0 - initial release
// ============================================================================
module tile_sched #(
    parameter int TILE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [TILE_W-1:0] cfg_tiles,
    output logic              cfg_ready,
    output logic              ld_start,
    input  logic              ld_done,
    output logic              cp_start,
    input  logic              cp_done,
    output logic              wb_start,
    input  logic              wb_done,
    output logic              state_rst,
    output logic [TILE_W:0]   phase,
    output logic              busy,
    output logic              layer_done
);

    localparam logic [TILE_W:0] C_ZERO = '0;
    localparam logic [TILE_W:0] C_ONE  = {{TILE_W{1'b0}}, 1'b1};
    localparam logic [TILE_W:0] C_TWO  = {{(TILE_W-1){1'b0}}, 2'b10};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_ROTATE = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t            state_q;
    logic [TILE_W-1:0] n_q;
    logic [TILE_W:0]   phase_q;
    logic [2:0]        pending_q;      // {wb, cp, ld}
    logic              ld_start_q;
    logic              cp_start_q;
    logic              wb_start_q;
    logic              state_rst_q;
    logic              layer_done_q;
    logic              cfg_ready_q;
    logic              busy_q;

    // Engine activity for phase k of an n-tile layer, returned as {wb, cp, ld}.
    // Both operands are TILE_W+1 bits wide so n+1 never wraps.
    function automatic logic [2:0] engines_active(input logic [TILE_W:0] k,
                                                  input logic [TILE_W:0] n);
        logic [2:0] a;
        a[0] = (k < n);
        a[1] = (k >= C_ONE) && (k <= n);
        a[2] = (k >= C_TWO) && (k <= (n + C_ONE));
        return a;
    endfunction

    logic [TILE_W:0] w_n_ext;
    logic [TILE_W:0] w_n_plus1;
    logic [TILE_W:0] w_phase_inc;
    logic [2:0]      w_done;
    logic [2:0]      w_act_first;
    logic [2:0]      w_act_next;

    assign w_n_ext     = {1'b0, n_q};
    assign w_n_plus1   = w_n_ext + C_ONE;
    assign w_phase_inc = phase_q + C_ONE;
    assign w_done      = {wb_done, cp_done, ld_done};
    assign w_act_first = engines_active(C_ZERO, {1'b0, cfg_tiles});
    assign w_act_next  = engines_active(w_phase_inc, w_n_ext);

    // Outputs are registered alongside the state so every pulse lines up
    // with the state it belongs to and no input reaches an output directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            phase_q      <= '0;
            pending_q    <= '0;
            ld_start_q   <= 1'b0;
            cp_start_q   <= 1'b0;
            wb_start_q   <= 1'b0;
            state_rst_q  <= 1'b0;
            layer_done_q <= 1'b0;
            cfg_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            ld_start_q   <= 1'b0;
            cp_start_q   <= 1'b0;
            wb_start_q   <= 1'b0;
            state_rst_q  <= 1'b0;
            layer_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cfg_ready_q <= 1'b1;
                    if (cfg_valid && cfg_ready_q) begin
                        n_q         <= cfg_tiles;
                        phase_q     <= '0;
                        cfg_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cfg_tiles != '0) begin
                            state_q <= S_LAUNCH;
                            {wb_start_q, cp_start_q, ld_start_q} <= w_act_first;
                            pending_q <= w_act_first;
                        end else begin
                            state_q      <= S_FINISH;
                            layer_done_q <= 1'b1;
                        end
                    end
                end
                // Done pulses in this cycle are deliberately not sampled.
                S_LAUNCH: state_q <= S_WAIT;
                // Rotation waits one cycle after the last pending bit drops;
                // dones for engines that are not pending simply mask to zero.
                S_WAIT: begin
                    if (pending_q == 3'b000) begin
                        state_q     <= S_ROTATE;
                        state_rst_q <= 1'b1;
                    end else begin
                        pending_q <= pending_q & ~w_done;
                    end
                end
                S_ROTATE: begin
                    phase_q <= w_phase_inc;
                    if (w_phase_inc <= w_n_plus1) begin
                        state_q <= S_LAUNCH;
                        {wb_start_q, cp_start_q, ld_start_q} <= w_act_next;
                        pending_q <= w_act_next;
                    end else begin
                        state_q      <= S_FINISH;
                        layer_done_q <= 1'b1;
                    end
                end
                S_FINISH: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    cfg_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign ld_start   = ld_start_q;
    assign cp_start   = cp_start_q;
    assign wb_start   = wb_start_q;
    assign state_rst  = state_rst_q;
    assign layer_done = layer_done_q;
    assign busy       = busy_q;
    assign phase      = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_sched
// Description : Scoreboard bench for tile_sched. Each directed layer pushes
//               its hand-computed sequence of output events (start pulses,
//               state_rst, layer_done, with phase) into a queue; a monitor
//               pops and compares whenever any pulse output is high. Engine
//               dones come from an automatic responder (fixed or tabled
//               delays) or are driven by hand for corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_sched;

    localparam int TW     = 16;
    localparam int SIG_LD = 0;
    localparam int SIG_CP = 1;
    localparam int SIG_WB = 2;
    localparam int SIG_DN = 4;

    logic          clk;
    logic          rst;
    logic          cfg_valid;
    logic [TW-1:0] cfg_tiles;
    logic          cfg_ready;
    logic          ld_start;
    logic          cp_start;
    logic          wb_start;
    logic          state_rst;
    logic [TW:0]   phase;
    logic          busy;
    logic          layer_done;

    logic [2:0]    auto_done;
    logic [2:0]    man_done;
    logic          auto_en;
    logic [2:0]    done_w;
    assign done_w = auto_en ? auto_done : man_done;

    tile_sched #(.TILE_W(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_tiles  (cfg_tiles),
        .cfg_ready  (cfg_ready),
        .ld_start   (ld_start),
        .ld_done    (done_w[0]),
        .cp_start   (cp_start),
        .cp_done    (done_w[1]),
        .wb_start   (wb_start),
        .wb_done    (done_w[2]),
        .state_rst  (state_rst),
        .phase      (phase),
        .busy       (busy),
        .layer_done (layer_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass;
    int          n_total;
    logic [21:0] exp_q[$];
    int          cnt_ld, cnt_cp, cnt_wb, cnt_sr, cnt_dn;
    int          dly_fix;
    bit          use_tbl;
    int          tbl_idx;
    int          cnt_e[3];
    int          dly_tbl[16] = '{3, 17, 1, 9, 20, 5, 12, 2, 8, 14, 1, 19, 6, 11, 4, 16};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Event vector: {ld_start, cp_start, wb_start, state_rst, layer_done, phase}
    task automatic push_launch(input logic [2:0] mask, input int ph);
        exp_q.push_back({mask[0], mask[1], mask[2], 2'b00, 17'(ph)});
    endtask

    task automatic push_phase(input logic [2:0] mask, input int ph);
        push_launch(mask, ph);
        exp_q.push_back({5'b00010, 17'(ph)});
    endtask

    task automatic push_fin(input int ph);
        exp_q.push_back({5'b00001, 17'(ph)});
    endtask

    task automatic clear_counts();
        cnt_ld = 0; cnt_cp = 0; cnt_wb = 0; cnt_sr = 0; cnt_dn = 0;
    endtask

    function automatic logic sel(input int w);
        case (w)
            SIG_LD:  return ld_start;
            SIG_CP:  return cp_start;
            SIG_WB:  return wb_start;
            default: return layer_done;
        endcase
    endfunction

    task automatic wait_sig(input int w, input int max_cyc, input string name, output int waited);
        waited = 0;
        while (sel(w) !== 1'b1 && waited < max_cyc) begin
            @(negedge clk);
            waited++;
        end
        chk(name, 32'(sel(w)), 32'd1);
    endtask

    task automatic accept(input int n);
        cfg_valid = 1'b1;
        cfg_tiles = TW'(n);
        step(1);
        cfg_valid = 1'b0;
    endtask

    // Scoreboard monitor
    initial begin
        logic [21:0] v;
        logic [21:0] e;
        forever begin
            @(negedge clk);
            v = {ld_start, cp_start, wb_start, state_rst, layer_done, phase};
            if (ld_start)   cnt_ld++;
            if (cp_start)   cnt_cp++;
            if (wb_start)   cnt_wb++;
            if (state_rst)  cnt_sr++;
            if (layer_done) cnt_dn++;
            if (v[21:17] != 5'b00000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected event", 32'(v), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event", 32'(v), 32'(e));
                end
            end
        end
    end

    // Automatic engine responder: done follows start after the chosen delay.
    initial begin
        auto_done = 3'b000;
        forever begin
            @(negedge clk);
            auto_done = 3'b000;
            if (!auto_en) begin
                for (int e = 0; e < 3; e++) cnt_e[e] = 0;
            end else begin
                for (int e = 0; e < 3; e++) begin
                    if (cnt_e[e] > 0) begin
                        cnt_e[e]--;
                        if (cnt_e[e] == 0) auto_done[e] = 1'b1;
                    end
                end
                for (int e = 0; e < 3; e++) begin
                    if ((e == 0 && ld_start) || (e == 1 && cp_start) || (e == 2 && wb_start)) begin
                        if (use_tbl) begin
                            cnt_e[e] = dly_tbl[tbl_idx];
                            tbl_idx  = (tbl_idx + 1) % 16;
                        end else begin
                            cnt_e[e] = dly_fix;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int first_sr;
        n_pass = 0; n_total = 0;
        rst = 1'b1; cfg_valid = 1'b0; cfg_tiles = '0;
        man_done = 3'b000; auto_en = 1'b0; dly_fix = 1; use_tbl = 0; tbl_idx = 0;
        clear_counts();

        // Reset state
        step(3);
        chk("rst cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rst outputs", 32'({busy, ld_start, cp_start, wb_start, state_rst, layer_done}), 32'd0);
        chk("rst phase", 32'(phase), 32'd0);
        rst = 1'b0;
        step(1);
        chk("cfg_ready after rst", 32'(cfg_ready), 32'd1);

        // N=1, dones one cycle after each start
        auto_en = 1'b1; clear_counts();
        push_phase(3'b001, 0); push_phase(3'b010, 1); push_phase(3'b100, 2); push_fin(3);
        accept(1);
        chk("n1 launch", 32'({busy, ld_start}), 32'd3);
        t = 0; first_sr = -1;
        while (layer_done !== 1'b1 && t < 100) begin
            if (state_rst === 1'b1 && first_sr < 0) first_sr = t;
            step(1);
            t++;
        end
        chk("n1 launch-to-rotate", 32'(first_sr), 32'd3);
        chk("n1 busy-rise-to-layer_done", 32'(t), 32'd12);
        step(1);
        chk("n1 idle after finish", 32'({cfg_ready, busy}), 32'd2);
        chk("n1 pulse counts", {8'(cnt_ld), 8'(cnt_cp), 8'(cnt_wb), 8'(cnt_sr)}, 32'h01010103);
        chk("n1 layer_done count", 32'(cnt_dn), 32'd1);
        chk("n1 drained", 32'(exp_q.size()), 32'd0);

        // N=4, out-of-order dones with delays 1..20
        use_tbl = 1; clear_counts();
        push_phase(3'b001, 0); push_phase(3'b011, 1); push_phase(3'b111, 2);
        push_phase(3'b111, 3); push_phase(3'b110, 4); push_phase(3'b100, 5); push_fin(6);
        accept(4);
        wait_sig(SIG_DN, 600, "n4 layer_done", t);
        step(1);
        chk("n4 pulse counts", {8'(cnt_ld), 8'(cnt_cp), 8'(cnt_wb), 8'(cnt_sr)}, 32'h04040406);
        chk("n4 drained", 32'(exp_q.size()), 32'd0);
        use_tbl = 0;

        // N=0
        clear_counts();
        push_fin(0);
        accept(0);
        chk("n0 layer_done next cycle", 32'({busy, layer_done}), 32'd3);
        step(1);
        chk("n0 cfg_ready back", 32'({cfg_ready, busy}), 32'd2);
        chk("n0 no starts", {8'(cnt_ld), 8'(cnt_cp), 8'(cnt_wb), 8'(cnt_sr)}, 32'd0);
        chk("n0 drained", 32'(exp_q.size()), 32'd0);

        // N=2, simultaneous dones, spurious and launch-cycle dones
        auto_en = 1'b0; clear_counts();
        push_phase(3'b001, 0); push_phase(3'b011, 1); push_phase(3'b110, 2);
        push_phase(3'b100, 3); push_fin(4);
        accept(2);
        step(1); man_done = 3'b001; step(1); man_done = 3'b000;
        wait_sig(SIG_CP, 10, "n2 p1 launch", t);
        step(1); man_done = 3'b111; step(1); man_done = 3'b000;
        step(1);
        chk("n2 rotate after joint dones", 32'(state_rst), 32'd1);
        step(1);
        chk("n2 p2 launch", 32'({cp_start, wb_start}), 32'd3);
        man_done = 3'b110;
        step(1); man_done = 3'b000;
        step(3);
        chk("n2 launch-cycle dones ignored", 32'({busy, state_rst, phase}), 32'({1'b1, 1'b0, 17'd2}));
        man_done = 3'b110; step(1); man_done = 3'b000; step(1);
        chk("n2 p2 rotate", 32'(state_rst), 32'd1);
        wait_sig(SIG_WB, 10, "n2 p3 launch", t);
        step(1); man_done = 3'b100; step(1); man_done = 3'b000;
        wait_sig(SIG_DN, 10, "n2 layer_done", t);
        step(1);
        chk("n2 idle", 32'({cfg_ready, busy}), 32'd2);
        chk("n2 drained", 32'(exp_q.size()), 32'd0);

        // N=5, reset in the WAIT of phase 2, then a clean N=2 layer
        clear_counts();
        push_phase(3'b001, 0); push_phase(3'b011, 1); push_launch(3'b111, 2);
        accept(5);
        step(1); man_done = 3'b001; step(1); man_done = 3'b000;
        wait_sig(SIG_CP, 10, "n5 p1 launch", t);
        step(1); man_done = 3'b011; step(1); man_done = 3'b000;
        wait_sig(SIG_WB, 10, "n5 p2 launch", t);
        step(1); man_done = 3'b001; step(1); man_done = 3'b000;
        step(2);
        chk("n5 waiting in p2", 32'({busy, phase}), 32'({1'b1, 17'd2}));
        rst = 1'b1;
        step(1);
        chk("n5 reset outputs",
            32'({cfg_ready, busy, ld_start, cp_start, wb_start, state_rst, layer_done, phase}), 32'd0);
        rst = 1'b0; man_done = 3'b010;
        step(1); man_done = 3'b000;
        chk("n5 cfg_ready after rst", 32'({cfg_ready, busy}), 32'd2);
        step(3);
        chk("n5 late cp_done no effect",
            32'({busy, ld_start, cp_start, wb_start, state_rst, layer_done, phase}), 32'd0);
        chk("n5 drained", 32'(exp_q.size()), 32'd0);
        auto_en = 1'b1; clear_counts();
        push_phase(3'b001, 0); push_phase(3'b011, 1); push_phase(3'b110, 2);
        push_phase(3'b100, 3); push_fin(4);
        accept(2);
        wait_sig(SIG_DN, 100, "post-rst layer_done", t);
        step(1);
        chk("post-rst pulse counts", {8'(cnt_ld), 8'(cnt_cp), 8'(cnt_wb), 8'(cnt_sr)}, 32'h02020204);
        chk("post-rst drained", 32'(exp_q.size()), 32'd0);

        // cfg_valid held high: back-to-back layers, N latched per accept
        clear_counts();
        push_phase(3'b001, 0); push_phase(3'b010, 1); push_phase(3'b100, 2); push_fin(3);
        push_phase(3'b001, 0); push_phase(3'b011, 1); push_phase(3'b110, 2);
        push_phase(3'b100, 3); push_fin(4);
        cfg_valid = 1'b1; cfg_tiles = TW'(1);
        step(1);
        chk("b2b first accept", 32'({busy, ld_start}), 32'd3);
        cfg_tiles = TW'(2);
        wait_sig(SIG_DN, 100, "b2b first layer_done", t);
        step(1);
        chk("b2b idle cycle", 32'({cfg_ready, busy}), 32'd2);
        step(1);
        chk("b2b second accept", 32'({busy, ld_start, cfg_ready}), 32'd6);
        cfg_valid = 1'b0;
        wait_sig(SIG_DN, 100, "b2b second layer_done", t);
        step(1);
        chk("b2b cfg_ready", 32'(cfg_ready), 32'd1);
        step(3);
        chk("b2b no third accept", 32'(busy), 32'd0);
        chk("b2b state_rst count", 32'(cnt_sr), 32'd7);
        chk("b2b drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
